fpu_share_arb: RTL and testbench

FPU_SHARE_ARB -- requirements
Module: fpu_share_arb

---
 rtl/fpu_share_arb_pkg.sv | 17 +
 rtl/fpu_share_arb_rr_pick.sv | 29 ++
 rtl/fpu_share_arb.sv | 115 +++++++++++
 tb/tb_fpu_share_arb.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_share_arb_pkg.sv
// Shared types and constants for the FPU sharing arbiter.
// State encoding and default sizing.
package fpu_share_arb_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int FPU_LAT_DEF = 4;
  localparam int FLT_W       = 32;
  localparam int OP_W        = 8;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/fpu_share_arb_rr_pick.sv
// Round-robin search: first set request at or above
// the pointer, wrapping from the top index back to 0.
module fpu_share_arb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_j;

  // Scan downward in distance so the nearest hit wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) begin
        o_idx = w_j;
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_share_arb.sv
// Arbitrates N requesters onto one fixed-latency FPU,
// holds each result until its owner accepts it.
module fpu_share_arb
  import fpu_share_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int FPU_LAT = FPU_LAT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*FLT_W-1:0] req_a,
  input  logic [N_REQ*FLT_W-1:0] req_b,
  input  logic [N_REQ*OP_W-1:0]  req_op,
  output logic [FLT_W-1:0]       fpu_a,
  output logic [FLT_W-1:0]       fpu_b,
  output logic [OP_W-1:0]        fpu_op,
  input  logic [FLT_W-1:0]       fpu_result,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [FLT_W-1:0]       rsp_data,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0] LAT_LAST = 4'(FPU_LAT - 1);

  state_t             r_state;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_rr_ptr;
  logic [3:0]         r_lat_cnt;
  logic [FLT_W-1:0]   r_fpu_a;
  logic [FLT_W-1:0]   r_fpu_b;
  logic [OP_W-1:0]    r_fpu_op;
  logic [FLT_W-1:0]   r_rsp_data;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [CNT_W-1:0]   r_op_count;

  logic [IW-1:0]      w_grant;
  logic               w_any;
  logic               w_accept;
  logic [IW-1:0]      w_next_ptr;

  fpu_share_arb_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_grant),
    .o_any (w_any)
  );

  assign w_accept   = (r_state == IDLE) && w_any;
  assign w_next_ptr = (w_grant == IW'(N_REQ - 1))
                    ? '0 : w_grant + 1'b1;

  assign req_ready = w_accept ? (N_REQ'(1) << w_grant) : '0;
  assign fpu_a     = r_fpu_a;
  assign fpu_b     = r_fpu_b;
  assign fpu_op    = r_fpu_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != IDLE);
  assign op_count  = r_op_count;

  // Controller: accept, count out the FPU latency, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_lat_cnt   <= '0;
      r_fpu_a     <= '0;
      r_fpu_b     <= '0;
      r_fpu_op    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= '0;
      r_op_count  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_owner   <= w_grant;
            r_fpu_a   <= req_a[FLT_W*int'(w_grant) +: FLT_W];
            r_fpu_b   <= req_b[FLT_W*int'(w_grant) +: FLT_W];
            r_fpu_op  <= req_op[OP_W*int'(w_grant) +: OP_W];
            r_rr_ptr  <= w_next_ptr;
            r_lat_cnt <= '0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          r_lat_cnt <= r_lat_cnt + 4'd1;
          if (r_lat_cnt == LAT_LAST) begin
            r_rsp_data  <= fpu_result;
            r_rsp_valid <= N_REQ'(1) << r_owner;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[r_owner]) begin
            r_rsp_valid <= '0;
            r_op_count  <= r_op_count + 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_share_arb.sv
// Scoreboard bench for fpu_share_arb with a table-based
// FPU adder model behind the shared FPU port.
module tb_fpu_share_arb;

  localparam int N   = 4;
  localparam int LAT = 4;

  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [127:0]  req_a;
  logic [127:0]  req_b;
  logic [31:0]   req_op;
  logic [31:0]   fpu_a;
  logic [31:0]   fpu_b;
  logic [7:0]    fpu_op;
  logic [31:0]   fpu_result;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [31:0]   rsp_data;
  logic          busy;
  logic [15:0]   op_count;

  int   exp_g[$];
  rsp_t exp_r[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   acc_n = 0;
  int   acc_cyc = 0;
  int   last_acc = -1;
  bit   chk_space = 1'b0;
  logic [N-1:0] prev_v = '0;

  // r0: 1+1, r1: 1+2, r2: 2+2, r3: 3+1
  assign req_a  = {F3, F2, F1, F1};
  assign req_b  = {F1, F2, F2, F1};
  assign req_op = {8'h01, 8'h01, 8'h01, 8'h01};

  function automatic logic [31:0] fadd(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [7:0]  op
  );
    if (op != 8'h01) return 32'h0;
    case ({a, b})
      {F1, F1}: return F2;
      {F1, F2}: return F3;
      {F2, F2}: return F4;
      {F3, F1}: return F4;
      default:  return 32'h7FC00000;
    endcase
  endfunction

  assign fpu_result = fadd(fpu_a, fpu_b, fpu_op);

  fpu_share_arb #(
    .N_REQ   (N),
    .FPU_LAT (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_op     (fpu_op),
    .fpu_result (fpu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Accept monitor: grant order and spacing.
  always @(negedge clk) begin
    if (rst_n && req_ready != '0) begin
      if (exp_g.size() == 0) begin
        chk("unexpected_accept", {28'b0, req_ready}, 32'h0);
      end else begin
        int g;
        g = exp_g.pop_front();
        chk("grant", {28'b0, req_ready}, 32'(1 << g));
      end
      if (chk_space && last_acc >= 0)
        chk("spacing", cyc + 1 - last_acc, LAT + 2);
      last_acc = cyc + 1;
      acc_cyc  = cyc + 1;
      acc_n++;
    end
  end

  // Response monitor: owner, data and latency.
  always @(negedge clk) begin
    if (rst_n && rsp_valid != '0 && prev_v == '0) begin
      chk("latency", cyc - acc_cyc, LAT);
      if (exp_r.size() == 0) begin
        chk("unexpected_rsp", {28'b0, rsp_valid}, 32'h0);
      end else begin
        rsp_t e;
        e = exp_r.pop_front();
        chk("rsp_valid", {28'b0, rsp_valid}, 32'(1 << e.idx));
        chk("rsp_data", rsp_data, e.data);
      end
    end
    prev_v = rsp_valid;
  end

  task automatic wait_acc(input int target);
    int k;
    k = 0;
    while (acc_n < target && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (acc_n < target) chk("accept_timeout", acc_n, target);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (busy) chk("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (rsp_valid == '0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (rsp_valid == '0) chk("rsp_timeout", 32'h0, 32'h1);
  endtask

  task automatic push(input int g, input bit r, input logic [31:0] d);
    rsp_t e;
    exp_g.push_back(g);
    if (r) begin
      e.idx  = g;
      e.data = d;
      exp_r.push_back(e);
    end
  endtask

  initial begin
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rsp_valid", {28'b0, rsp_valid}, 32'h0);
    chk("rst_op_count", {16'b0, op_count}, 32'h0);
    chk("rst_fpu_a", fpu_a, 32'h0);
    chk("rst_fpu_b", fpu_b, 32'h0);
    chk("rst_fpu_op", {24'b0, fpu_op}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single request from requester 1
    push(1, 1'b1, F3);
    req_valid = 4'b0010;
    wait_acc(1);
    req_valid = '0;
    chk("t1_fpu_a", fpu_a, F1);
    chk("t1_fpu_b", fpu_b, F2);
    chk("t1_fpu_op", {24'b0, fpu_op}, 32'h01);
    wait_rsp();
    chk("t1_cnt_before", {16'b0, op_count}, 32'd0);
    rsp_ready = 4'b0010;
    @(posedge clk);
    #1;
    rsp_ready = '0;
    chk("t1_cnt_after", {16'b0, op_count}, 32'd1);
    chk("t1_idle", {31'b0, busy}, 32'h0);

    // rotation under full load from reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(0, 1'b1, F2);
    push(1, 1'b1, F3);
    push(2, 1'b1, F4);
    push(3, 1'b1, F4);
    push(0, 1'b1, F2);
    last_acc  = -1;
    chk_space = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    wait_acc(acc_n + 5);
    req_valid = '0;
    wait_idle();
    chk_space = 1'b0;
    chk("t2_cnt", {16'b0, op_count}, 32'd5);

    // backpressure; non-owner ready bits are set
    push(0, 1'b1, F2);
    rsp_ready = 4'b1110;
    req_valid = 4'b0001;
    wait_acc(acc_n + 1);
    req_valid = 4'b1000;
    wait_rsp();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", {28'b0, rsp_valid}, 32'h1);
      chk("bp_data", rsp_data, F2);
      chk("bp_busy", {31'b0, busy}, 32'h1);
      chk("bp_ready", {28'b0, req_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    push(3, 1'b1, F4);
    rsp_ready = 4'b1111;
    wait_acc(acc_n + 1);
    req_valid = '0;
    wait_idle();

    // requester 3 drops out while 1 is served
    push(1, 1'b1, F3);
    req_valid = 4'b0010;
    wait_acc(acc_n + 1);
    req_valid = 4'b1000;
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("drop_grants_left", exp_g.size(), 32'd0);
    chk("drop_rsp_left", exp_r.size(), 32'd0);

    // reset two cycles into WAIT
    push(0, 1'b0, 32'h0);
    req_valid = 4'b0001;
    wait_acc(acc_n + 1);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'b0, busy}, 32'h0);
    chk("mid_rsp_valid", {28'b0, rsp_valid}, 32'h0);
    chk("mid_fpu_a", fpu_a, 32'h0);
    chk("mid_fpu_op", {24'b0, fpu_op}, 32'h0);
    chk("mid_rsp_data", rsp_data, 32'h0);
    chk("mid_op_count", {16'b0, op_count}, 32'h0);
    #3;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_no_rsp", {28'b0, rsp_valid}, 32'h0);
    push(0, 1'b1, F2);
    push(2, 1'b1, F4);
    req_valid = 4'b0101;
    wait_acc(acc_n + 2);
    req_valid = '0;
    wait_idle();
    chk("mid_cnt", {16'b0, op_count}, 32'd2);

    // counter wrap from a preloaded value
    @(negedge clk);
    force dut.r_op_count = 16'hFFFE;
    #1;
    release dut.r_op_count;
    @(posedge clk);
    #1;
    push(1, 1'b1, F3);
    req_valid = 4'b0010;
    wait_acc(acc_n + 1);
    req_valid = '0;
    wait_idle();
    chk("wrap_ffff", {16'b0, op_count}, 32'h0000FFFF);
    push(2, 1'b1, F4);
    req_valid = 4'b0100;
    wait_acc(acc_n + 1);
    req_valid = '0;
    wait_idle();
    chk("wrap_zero", {16'b0, op_count}, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("end_grants_left", exp_g.size(), 32'd0);
    chk("end_rsp_left", exp_r.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
